// File: rtl/iot_event_serializer.sv
// Turns per-device online/offline transitions into a stream of single-cycle
// change/on_off events, one per clock, picked round-robin across devices.
module iot_event_serializer #(
   parameter int N_DEV = 8,
   parameter int ID_W  = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N_DEV-1:0] dev_active,
   output logic             change,
   output logic             on_off,
   output logic [ID_W-1:0]  dev_id,
   output logic             pend_any
);

   logic [N_DEV-1:0] prev_q;
   logic [N_DEV-1:0] pend_v;
   logic [N_DEV-1:0] pend_dir;
   logic [N_DEV-1:0] rise;
   logic [N_DEV-1:0] fall;
   logic [N_DEV-1:0] pend_v_n;
   logic [N_DEV-1:0] pend_dir_n;
   logic [ID_W-1:0]  ptr;
   logic [ID_W-1:0]  idx;
   logic             gnt_v;
   logic [ID_W-1:0]  gnt_id;

   assign rise = dev_active & ~prev_q;
   assign fall = ~dev_active & prev_q;

   // Scan farthest-first so the device nearest after the pointer wins last.
   always_comb begin
      gnt_v  = 1'b0;
      gnt_id = '0;
      idx    = '0;
      for (int k = N_DEV; k >= 1; k--) begin
         idx = ID_W'((int'(ptr) + k) % N_DEV);
         if (pend_v[idx]) begin
            gnt_v  = 1'b1;
            gnt_id = idx;
         end
      end
   end

   // Clearing the granted slot first lets a same-cycle edge on it be stored fresh,
   // while an edge against a still-pending event cancels it.
   always_comb begin
      pend_v_n   = pend_v;
      pend_dir_n = pend_dir;
      if (gnt_v) begin
         pend_v_n[gnt_id] = 1'b0;
      end
      for (int i = 0; i < N_DEV; i++) begin
         if (rise[i] | fall[i]) begin
            if (pend_v_n[i]) begin
               pend_v_n[i] = 1'b0;
            end else begin
               pend_v_n[i]   = 1'b1;
               pend_dir_n[i] = rise[i];
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prev_q   <= '0;
         pend_v   <= '0;
         pend_dir <= '0;
         ptr      <= ID_W'(N_DEV - 1);
         change   <= 1'b0;
         on_off   <= 1'b0;
         dev_id   <= '0;
         pend_any <= 1'b0;
      end else begin
         prev_q   <= dev_active;
         pend_v   <= pend_v_n;
         pend_dir <= pend_dir_n;
         pend_any <= |pend_v_n;
         change   <= gnt_v;
         on_off   <= gnt_v & pend_dir[gnt_id];
         dev_id   <= gnt_v ? gnt_id : '0;
         if (gnt_v) begin
            ptr <= gnt_id;
         end
      end
   end

endmodule

// File: tb/tb_iot_event_serializer.sv
// Checks iot_event_serializer cycle by cycle against an event-level reference
// model, with directed scenarios followed by random activity.
module tb_iot_event_serializer;

   logic       clk;
   logic       rst_n;
   logic [7:0] dev_active;
   logic       change;
   logic       on_off;
   logic [2:0] dev_id;
   logic       pend_any;

   int checks;
   int errors;
   int pulse_cnt;
   int dut_count;
   logic seen7;

   // Reference model: last seen level and a signed pending event per device.
   bit m_prev [8];
   int m_pend [8];
   int m_ptr;
   logic       exp_change;
   logic       exp_onoff;
   logic [2:0] exp_id;
   logic       exp_any;
   logic [7:0] cur;

   iot_event_serializer #(.N_DEV(8), .ID_W(3)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .dev_active(dev_active),
      .change(change),
      .on_off(on_off),
      .dev_id(dev_id),
      .pend_any(pend_any)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   task automatic modelReset();
      for (int i = 0; i < 8; i++) begin
         m_prev[i] = 1'b0;
         m_pend[i] = 0;
      end
      m_ptr      = 7;
      exp_change = 1'b0;
      exp_onoff  = 1'b0;
      exp_id     = 3'd0;
      exp_any    = 1'b0;
      dut_count  = 0;
   endtask

   task automatic modelStep(input logic [7:0] a);
      int g;
      g = -1;
      for (int k = 1; k <= 8; k++) begin
         if (g < 0 && m_pend[(m_ptr + k) % 8] != 0) g = (m_ptr + k) % 8;
      end
      if (g >= 0) begin
         exp_change = 1'b1;
         exp_onoff  = (m_pend[g] > 0);
         exp_id     = 3'(g);
         m_ptr      = g;
         m_pend[g]  = 0;
      end else begin
         exp_change = 1'b0;
         exp_onoff  = 1'b0;
         exp_id     = 3'd0;
      end
      exp_any = 1'b0;
      for (int i = 0; i < 8; i++) begin
         if (a[i] != m_prev[i]) begin
            if (m_pend[i] != 0) m_pend[i] = 0;
            else m_pend[i] = a[i] ? 1 : -1;
            m_prev[i] = a[i];
         end
         if (m_pend[i] != 0) exp_any = 1'b1;
      end
   endtask

   task automatic applyStimulus(input logic [7:0] a);
      dev_active = a;
      cur = a;
      @(posedge clk);
      modelStep(a);
      #1;
      checkOutput("change", 32'(change), 32'(exp_change));
      checkOutput("on_off", 32'(on_off), 32'(exp_onoff));
      checkOutput("dev_id", 32'(dev_id), 32'(exp_id));
      checkOutput("pend_any", 32'(pend_any), 32'(exp_any));
      if (change) begin
         pulse_cnt++;
         if (dev_id == 3'd7) seen7 = 1'b1;
         dut_count += on_off ? 1 : -1;
      end
   endtask

   task automatic drain(input int n);
      for (int i = 0; i < n; i++) applyStimulus(cur);
   endtask

   task automatic checkScoreboard(input string tag);
      checkOutput({tag, "_idle"}, 32'(pend_any), 32'd0);
      checkOutput({tag, "_count"}, 32'(dut_count), 32'($countones(cur)));
   endtask

   initial begin
      checks     = 0;
      errors     = 0;
      pulse_cnt  = 0;
      seen7      = 1'b0;
      cur        = 8'h00;
      dev_active = 8'h00;
      rst_n      = 1'b0;
      modelReset();
      #12;
      checkOutput("rst_change", 32'(change), 32'd0);
      checkOutput("rst_on_off", 32'(on_off), 32'd0);
      checkOutput("rst_dev_id", 32'(dev_id), 32'd0);
      checkOutput("rst_pend_any", 32'(pend_any), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      $display("[TB] idle after reset");
      drain(10);

      $display("[TB] all devices join at once");
      applyStimulus(8'hFF);
      for (int i = 0; i < 8; i++) begin
         applyStimulus(8'hFF);
         checkOutput("burst_id", 32'(dev_id), 32'(i));
         checkOutput("burst_dir", 32'(on_off), 32'd1);
      end
      checkOutput("burst_done", 32'(pend_any), 32'd0);
      checkScoreboard("burst");
      applyStimulus(8'h00);
      drain(9);
      checkScoreboard("leave_all");

      $display("[TB] single join latency");
      applyStimulus(8'h01);
      checkOutput("lat_k", 32'(change), 32'd0);
      applyStimulus(8'h01);
      checkOutput("lat_k1_change", 32'(change), 32'd1);
      checkOutput("lat_k1_dir", 32'(on_off), 32'd1);
      checkOutput("lat_k1_id", 32'(dev_id), 32'd0);
      applyStimulus(8'h01);
      checkOutput("lat_k2_change", 32'(change), 32'd0);

      $display("[TB] round-robin fairness");
      applyStimulus(8'h09);
      applyStimulus(8'h09);
      checkOutput("rr_ptr3", 32'(dev_id), 32'd3);
      applyStimulus(8'h2D);
      applyStimulus(8'h2D);
      checkOutput("rr_first", 32'(dev_id), 32'd5);
      applyStimulus(8'h2D);
      checkOutput("rr_second", 32'(dev_id), 32'd2);
      drain(3);
      checkScoreboard("rr");

      $display("[TB] cancel of a short toggle");
      applyStimulus(8'h00);
      drain(6);
      pulse_cnt = 0;
      seen7     = 1'b0;
      applyStimulus(8'h7F);
      applyStimulus(8'hFF);
      applyStimulus(8'h7F);
      drain(10);
      checkOutput("cancel_pulses", 32'(pulse_cnt), 32'd7);
      checkOutput("cancel_no_dev7", 32'(seen7), 32'd0);
      checkScoreboard("cancel");

      $display("[TB] reset in the middle of a burst");
      applyStimulus(8'h00);
      drain(10);
      applyStimulus(8'hFF);
      drain(3);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("mid_rst_change", 32'(change), 32'd0);
      checkOutput("mid_rst_on_off", 32'(on_off), 32'd0);
      checkOutput("mid_rst_dev_id", 32'(dev_id), 32'd0);
      checkOutput("mid_rst_pend_any", 32'(pend_any), 32'd0);
      modelReset();
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      applyStimulus(8'hFF);
      for (int i = 0; i < 8; i++) begin
         applyStimulus(8'hFF);
         checkOutput("rejoin_id", 32'(dev_id), 32'(i));
         checkOutput("rejoin_dir", 32'(on_off), 32'd1);
      end
      checkScoreboard("rejoin");

      $display("[TB] random activity");
      for (int r = 0; r < 20; r++) begin
         for (int i = 0; i < 15; i++) begin
            case ($urandom_range(0, 3))
               0: applyStimulus(cur ^ 8'($urandom_range(0, 255)));
               1: applyStimulus(cur ^ (8'd1 << $urandom_range(0, 7)));
               default: applyStimulus(cur);
            endcase
         end
         drain(10);
         checkScoreboard("random");
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
